// File: rtl/l2_arbiter_if.sv
// Bus bundle for l2_arbiter: I-cache requester, D-cache requester and the shared L2 port.
// The slave modport is the arbiter's view; master is the caches-plus-L2 environment.
interface l2_arbiter_if;
  logic         i_read;
  logic [31:0]  i_address;
  logic [255:0] i_rdata;
  logic         i_resp;

  logic         d_read;
  logic         d_write;
  logic [31:0]  d_address;
  logic [255:0] d_wdata;
  logic [255:0] d_rdata;
  logic         d_resp;

  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_address;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;
  logic         mem_resp;

  modport slave (
    input  i_read, i_address,
    output i_rdata, i_resp,
    input  d_read, d_write, d_address, d_wdata,
    output d_rdata, d_resp,
    output mem_read, mem_write, mem_address, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport master (
    output i_read, i_address,
    input  i_rdata, i_resp,
    output d_read, d_write, d_address, d_wdata,
    input  d_rdata, d_resp,
    input  mem_read, mem_write, mem_address, mem_wdata,
    output mem_rdata, mem_resp
  );
endinterface

// File: rtl/l2_arbiter.sv
// Shares one L2 line port between the I-cache and D-cache, one transaction at a time.
// RR_EN=1 alternates grants under contention; RR_EN=0 always favours the D side.
module l2_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input logic         clk,
  input logic         rst_n,
  l2_arbiter_if.slave bus
);
  // state  | meaning
  // IDLE   | no transaction; arbitrate on every edge
  // BUSY_I | I-side line read outstanding on L2
  // BUSY_D | D-side line read or write-back outstanding on L2
  // DONE_I | i_resp pulse, i_rdata valid
  // DONE_D | d_resp pulse, d_rdata valid
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    DONE_I = 3'd3,
    DONE_D = 3'd4
  } state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } side_t;

  state_t        state_q;
  side_t         last_grant_q;
  logic          mem_read_q;
  logic          mem_write_q;
  logic [31:0]   mem_address_q;
  logic [255:0]  mem_wdata_q;
  logic [255:0]  i_rdata_q;
  logic [255:0]  d_rdata_q;
  logic          i_resp_q;
  logic          d_resp_q;

  logic          i_req;
  logic          d_req;
  logic          grant_i_d;
  logic          grant_d_d;

  assign i_req = bus.i_read;
  assign d_req = bus.d_read | bus.d_write;

  always_comb begin
    grant_i_d = 1'b0;
    grant_d_d = 1'b0;
    if (i_req && d_req) begin
      if (RR_EN && (last_grant_q == GNT_D)) grant_i_d = 1'b1;
      else                                  grant_d_d = 1'b1;
    end else if (i_req) begin
      grant_i_d = 1'b1;
    end else if (d_req) begin
      grant_d_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_grant_q  <= GNT_I;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      i_rdata_q     <= '0;
      d_rdata_q     <= '0;
      i_resp_q      <= 1'b0;
      d_resp_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_d_d) begin
            state_q       <= BUSY_D;
            last_grant_q  <= GNT_D;
            mem_address_q <= bus.d_address;
            // a simultaneous read and write-back request is served as the write-back
            if (bus.d_write) begin
              mem_write_q <= 1'b1;
              mem_wdata_q <= bus.d_wdata;
            end else begin
              mem_read_q  <= 1'b1;
            end
          end else if (grant_i_d) begin
            state_q       <= BUSY_I;
            last_grant_q  <= GNT_I;
            mem_address_q <= bus.i_address;
            mem_read_q    <= 1'b1;
          end
        end
        BUSY_I: begin
          if (bus.mem_resp) begin
            state_q     <= DONE_I;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            i_rdata_q   <= bus.mem_rdata;
            i_resp_q    <= 1'b1;
          end
        end
        BUSY_D: begin
          if (bus.mem_resp) begin
            state_q     <= DONE_D;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            if (mem_read_q) d_rdata_q <= bus.mem_rdata;
            d_resp_q    <= 1'b1;
          end
        end
        DONE_I: begin
          state_q  <= IDLE;
          i_resp_q <= 1'b0;
        end
        DONE_D: begin
          state_q  <= IDLE;
          d_resp_q <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          i_resp_q    <= 1'b0;
          d_resp_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_read    = mem_read_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.i_rdata     = i_rdata_q;
  assign bus.i_resp      = i_resp_q;
  assign bus.d_rdata     = d_rdata_q;
  assign bus.d_resp      = d_resp_q;
endmodule

// File: tb/tb_l2_arbiter.sv
// Scoreboard bench for l2_arbiter: randomized cache requests, an L2 responder with random
// latency, and a monitor that checks every x_resp against a service-order reference model.
module tb_l2_arbiter;
  localparam bit RR_MODEL = 1'b1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  l2_arbiter_if bus();
  l2_arbiter_if bus_f();

  l2_arbiter #(.RR_EN(1'b1)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  l2_arbiter #(.RR_EN(1'b0)) u_fix (.clk(clk), .rst_n(rst_n), .bus(bus_f));

  typedef struct packed {
    logic         side;   // 0 = I, 1 = D
    logic [31:0]  addr;
    logic         wr;
    logic [255:0] wdata;
  } mem_txn_t;

  typedef struct packed {
    logic         side;
    logic [255:0] rdata;
  } resp_t;

  mem_txn_t     mem_exp[$];
  resp_t        resp_exp[$];
  logic         last_side = 1'b0;
  logic [255:0] model_rdata [2];
  int           n_checks = 0;
  int           n_pass = 0;
  int           cyc = 0;
  int           resp_due = -1;
  int           forced_lat = 0;
  bit           use_forced_rd = 1'b0;
  logic [255:0] forced_rd = '0;
  bit           fix_run = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [255:0] rnd_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // L2 model: serves whatever the arbiter puts on mem_*, checks it against the expected order
  initial begin
    bit           busy;
    int           cnt;
    int           lat;
    mem_txn_t     t;
    resp_t        r;
    logic [255:0] rd;
    busy = 1'b0; cnt = 0; lat = 1; t = '0;
    bus.mem_resp = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 1'b0;
        bus.mem_resp = 1'b0;
        continue;
      end
      if (bus.mem_read && bus.mem_write)
        chk(1'b0, "mem_rd_wr_together", 256'd3, 256'd0);
      if (bus.mem_resp) begin
        bus.mem_resp = 1'b0;
        chk(!(bus.mem_read || bus.mem_write), "mem_op_drop_after_resp",
            {254'd0, bus.mem_read, bus.mem_write}, 256'd0);
        busy = 1'b0;
      end else if (bus.mem_read || bus.mem_write) begin
        if (!busy) begin
          if (mem_exp.size() == 0) begin
            chk(1'b0, "mem_unexpected_request", bus.mem_address, 256'd0);
            t = '0;
          end else begin
            t = mem_exp.pop_front();
            chk(bus.mem_address == t.addr, "mem_address", bus.mem_address, t.addr);
            chk(bus.mem_write == t.wr, "mem_op_write", bus.mem_write, t.wr);
            if (t.wr) chk(bus.mem_wdata == t.wdata, "mem_wdata", bus.mem_wdata, t.wdata);
          end
          busy = 1'b1;
          cnt = 0;
          lat = (forced_lat != 0) ? forced_lat : int'($urandom_range(1, 6));
        end else begin
          chk(bus.mem_address == t.addr, "mem_address_stable", bus.mem_address, t.addr);
          if (t.wr) chk(bus.mem_wdata == t.wdata, "mem_wdata_stable", bus.mem_wdata, t.wdata);
        end
        cnt++;
        if (cnt == lat) begin
          rd = use_forced_rd ? forced_rd : rnd_line();
          if (!t.wr) model_rdata[t.side] = rd;
          bus.mem_rdata = rd;
          bus.mem_resp = 1'b1;
          r.side = t.side;
          r.rdata = model_rdata[t.side];
          resp_exp.push_back(r);
          resp_due = cyc + 1;
        end
      end else if (busy) begin
        chk(1'b0, "mem_op_dropped_early", 256'd0, 256'd1);
        busy = 1'b0;
      end
    end
  end

  // monitor: every i_resp/d_resp pops one expected response
  initial begin
    bit    prev_resp;
    resp_t r;
    logic  side;
    prev_resp = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_resp = 1'b0;
        continue;
      end
      if (bus.i_resp && bus.d_resp) chk(1'b0, "resp_both_high", 256'd3, 256'd0);
      if (bus.i_resp || bus.d_resp) begin
        side = bus.d_resp;
        chk(!prev_resp, "resp_single_pulse", 256'd1, 256'd0);
        if (resp_exp.size() == 0) begin
          chk(1'b0, "resp_unexpected", {255'd0, side}, 256'd0);
        end else begin
          r = resp_exp.pop_front();
          chk(side == r.side, "resp_side", {255'd0, side}, {255'd0, r.side});
          chk(cyc == resp_due, "resp_latency", cyc, resp_due);
          chk(bus.i_rdata == model_rdata[0], "i_rdata", bus.i_rdata, model_rdata[0]);
          chk(bus.d_rdata == model_rdata[1], "d_rdata", bus.d_rdata, model_rdata[1]);
        end
      end
      prev_resp = bus.i_resp || bus.d_resp;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      bus_f.mem_resp = fix_run && (bus_f.mem_read || bus_f.mem_write) && !bus_f.mem_resp;
    end
  end

  // dop: 0 = d_read, 1 = d_write, 2 = both (served as write)
  task automatic issue(input bit wi, input bit wd, input int dop,
                       input logic [31:0] ia, input logic [31:0] da, input logic [255:0] dw);
    mem_txn_t ti, td;
    logic     order [2];
    logic     first;
    int       n, k, cycles;
    bit       pend_i, pend_d, op_prev;
    ti = '{side: 1'b0, addr: ia, wr: 1'b0, wdata: '0};
    td = '{side: 1'b1, addr: da, wr: (dop != 0), wdata: dw};
    n = 0;
    if (wi && wd) begin
      first = RR_MODEL ? ~last_side : 1'b1;
      order[0] = first; order[1] = ~first; n = 2;
    end else if (wi) begin
      order[0] = 1'b0; n = 1;
    end else if (wd) begin
      order[0] = 1'b1; n = 1;
    end
    for (int j = 0; j < n; j++) begin
      mem_exp.push_back(order[j] ? td : ti);
      last_side = order[j];
    end
    bus.i_read    = wi;
    bus.i_address = ia;
    bus.d_read    = wd && (dop != 1);
    bus.d_write   = wd && (dop != 0);
    bus.d_address = da;
    bus.d_wdata   = dw;
    pend_i = wi; pend_d = wd; k = 0; op_prev = 1'b0; cycles = 0;
    while ((pend_i || pend_d) && cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (bus.i_resp) begin bus.i_read = 1'b0; pend_i = 1'b0; end
      if (bus.d_resp) begin bus.d_read = 1'b0; bus.d_write = 1'b0; pend_d = 1'b0; end
      // once a side is granted, disturb its inputs; the L2 side must not notice
      if ((bus.mem_read || bus.mem_write) && !op_prev && k < n) begin
        if (order[k]) begin
          bus.d_address = bus.d_address + 32'h2000;
          bus.d_wdata   = ~bus.d_wdata;
        end else begin
          bus.i_address = bus.i_address + 32'h2000;
        end
        k++;
      end
      op_prev = bus.mem_read || bus.mem_write;
    end
    chk(!(pend_i || pend_d), "issue_completes", {254'd0, pend_i, pend_d}, 256'd0);
    bus.i_read = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string pfx);
    chk(bus.mem_read == 1'b0,  {pfx, "_mem_read"},  bus.mem_read, 256'd0);
    chk(bus.mem_write == 1'b0, {pfx, "_mem_write"}, bus.mem_write, 256'd0);
    chk(bus.mem_address == '0, {pfx, "_mem_address"}, bus.mem_address, 256'd0);
    chk(bus.mem_wdata == '0,   {pfx, "_mem_wdata"}, bus.mem_wdata, 256'd0);
    chk(bus.i_rdata == '0,     {pfx, "_i_rdata"}, bus.i_rdata, 256'd0);
    chk(bus.d_rdata == '0,     {pfx, "_d_rdata"}, bus.d_rdata, 256'd0);
    chk(bus.i_resp == 1'b0,    {pfx, "_i_resp"}, bus.i_resp, 256'd0);
    chk(bus.d_resp == 1'b0,    {pfx, "_d_resp"}, bus.d_resp, 256'd0);
  endtask

  initial begin
    logic [255:0] d_before;
    logic [31:0]  ia, da;
    int           t, ngr;
    bit           prev;
    model_rdata[0] = '0; model_rdata[1] = '0;
    bus.i_read = 1'b0; bus.i_address = '0;
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_address = '0; bus.d_wdata = '0;
    bus_f.i_read = 1'b0; bus_f.i_address = '0;
    bus_f.d_read = 1'b0; bus_f.d_write = 1'b0; bus_f.d_address = '0; bus_f.d_wdata = '0;
    bus_f.mem_rdata = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // contention straight out of reset: D, I, D, I, ...
    for (int j = 0; j < 4; j++)
      issue(1'b1, 1'b1, int'($urandom_range(0, 2)), 32'h0000_8000 + j * 64, 32'h0000_9020 + j * 64, rnd_line());

    forced_lat = 5; use_forced_rd = 1'b1; forced_rd = {32{8'hA5}};
    issue(1'b1, 1'b0, 0, 32'h0000_1000, 32'h0, '0);
    chk(bus.i_rdata == {32{8'hA5}}, "i_read_a5_line", bus.i_rdata, {32{8'hA5}});
    use_forced_rd = 1'b0;

    forced_lat = 3;
    d_before = bus.d_rdata;
    issue(1'b0, 1'b1, 1, 32'h0, 32'h0000_2040, {8{32'h1234_5678}});
    chk(bus.d_rdata == d_before, "d_write_keeps_rdata", bus.d_rdata, d_before);
    forced_lat = 0;

    // stray mem_resp while idle must be ignored
    @(negedge clk);
    #1 bus.mem_resp = 1'b1;
    repeat (3) @(negedge clk);
    chk(!(bus.i_resp || bus.d_resp), "spurious_resp_ignored", {254'd0, bus.i_resp, bus.d_resp}, 256'd0);
    chk(!(bus.mem_read || bus.mem_write), "spurious_no_mem_op", {254'd0, bus.mem_read, bus.mem_write}, 256'd0);

    for (int j = 0; j < 40; j++) begin
      ia = $urandom & 32'hFFFF_FFC0;
      da = ($urandom & 32'hFFFF_FFC0) | 32'h20;
      case ($urandom_range(0, 2))
        0:       issue(1'b1, 1'b0, 0, ia, da, rnd_line());
        1:       issue(1'b0, 1'b1, int'($urandom_range(0, 2)), ia, da, rnd_line());
        default: issue(1'b1, 1'b1, int'($urandom_range(0, 2)), ia, da, rnd_line());
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // reset two cycles into a D write-back
    @(negedge clk);
    forced_lat = 20;
    mem_exp.push_back('{side: 1'b1, addr: 32'h0000_4000, wr: 1'b1, wdata: {8{32'hCAFE_F00D}}});
    bus.d_write = 1'b1; bus.d_address = 32'h0000_4000; bus.d_wdata = {8{32'hCAFE_F00D}};
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.mem_write && t < 20);
    chk(bus.mem_write, "rst_busy_d_reached", bus.mem_write, 256'd1);
    bus.d_write = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_outputs_zero("async_rst");
    mem_exp.delete(); resp_exp.delete();
    last_side = 1'b0; model_rdata[0] = '0; model_rdata[1] = '0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    forced_lat = 0;
    issue(1'b1, 1'b0, 0, 32'h0000_7000, 32'h0, '0);
    chk(!bus.d_resp, "no_d_resp_after_rst", bus.d_resp, 256'd0);

    // fixed D priority instance: D held continuously keeps winning
    @(negedge clk);
    fix_run = 1'b1;
    bus_f.i_address = 32'h0000_5000; bus_f.d_address = 32'h0000_6000;
    bus_f.i_read = 1'b1; bus_f.d_read = 1'b1;
    ngr = 0; t = 0; prev = 1'b0;
    while (ngr < 5 && t < 100) begin
      @(negedge clk);
      t++;
      if (bus_f.mem_read && !prev) begin
        if (ngr < 4) chk(bus_f.mem_address == 32'h0000_6000, "fix_d_priority", bus_f.mem_address, 32'h0000_6000);
        else         chk(bus_f.mem_address == 32'h0000_5000, "fix_i_after_d", bus_f.mem_address, 32'h0000_5000);
        ngr++;
        if (ngr == 4) bus_f.d_read = 1'b0;
      end
      prev = bus_f.mem_read;
    end
    chk(ngr == 5, "fix_grant_count", ngr, 5);
    bus_f.i_read = 1'b0;
    repeat (4) @(negedge clk);
    chk(mem_exp.size() == 0 && resp_exp.size() == 0, "scoreboard_drained",
        mem_exp.size() + resp_exp.size(), 256'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
